// File: rtl/dp_mem_pkg.sv
// ---------------------------------------------------------------------------
// dp_mem_pkg
// Shared definitions for the dp_mem_param block.
//   - DATA_W_DEF / ADDR_W_DEF : default data width and address width
//   - clr_state_t             : state encoding of the clear sequencer FSM
// ---------------------------------------------------------------------------
package dp_mem_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 9;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } clr_state_t;

endpackage : dp_mem_pkg

// File: rtl/dp_mem_clr_seq.sv
// ---------------------------------------------------------------------------
// dp_mem_clr_seq
// Clear sequencer: sweeps every address once, one word per cycle from 0,
// then parks in READY until a new clear request arrives.
// Ports:
//   clk      : clock
//   srst     : synchronous active-high reset (forces CLEAR, counter 0)
//   clr      : re-run request; restarts the sweep at address 0
//   busy     : 1 in every CLEAR cycle
//   clr_addr : address being cleared this cycle
//   clr_we   : write strobe for the clear word
// ---------------------------------------------------------------------------
module dp_mem_clr_seq
    import dp_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              clr,
    output logic              busy,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_we
);

    clr_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= ST_CLEAR;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_CLEAR: begin
                if (clr) begin
                    cnt_next = '0;
                end else begin
                    // Counter wraps to 0 naturally after the last address.
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == {ADDR_W{1'b1}}) begin
                        state_next = ST_READY;
                    end
                end
            end
            ST_READY: begin
                if (clr) begin
                    state_next = ST_CLEAR;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    assign busy     = (state_reg == ST_CLEAR);
    assign clr_addr = cnt_reg;
    // No array writes while reset is held; the sweep itself initialises it.
    assign clr_we   = busy & ~srst;

endmodule : dp_mem_clr_seq

// File: rtl/dp_mem_param.sv
// ---------------------------------------------------------------------------
// dp_mem_param
// Simple dual-port memory (one write port, one read port) with a built-in
// clear sweep after reset or on request.
// Config macro: DP_MEM_BYPASS_EN -- when defined, a same-address read and
// write in one cycle returns the new write data (write-first); otherwise
// the previously stored word (read-first).
// Ports:
//   i_clk    : clock
//   i_rst    : synchronous active-high reset
//   i_clr    : one-cycle request to re-run the clear sweep
//   i_we     : write enable      i_waddr : write address  i_wdata : write data
//   i_re     : read enable       i_raddr : read address
//   o_rdata  : registered read data (holds when no read is accepted)
//   o_rvalid : o_rdata updated this cycle
//   o_busy   : clear sweep in progress; user accesses are ignored
// ---------------------------------------------------------------------------
module dp_mem_param
    import dp_mem_pkg::*;
#(
    parameter int                DATA_W  = DATA_W_DEF,
    parameter int                ADDR_W  = ADDR_W_DEF,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rvalid,
    output logic              o_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic              busy;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_we;

    dp_mem_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk      (i_clk),
        .srst     (i_rst),
        .clr      (i_clr),
        .busy     (busy),
        .clr_addr (clr_addr),
        .clr_we   (clr_we)
    );

    // User accesses only count outside the sweep.
    logic user_we, user_re;
    assign user_we = i_we & ~busy;
    assign user_re = i_re & ~busy;

    // Single write port shared by the sweep and the user.
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    assign wr_en   = clr_we | user_we;
    assign wr_addr = busy ? clr_addr : i_waddr;
    assign wr_data = busy ? CLR_VAL  : i_wdata;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    logic [DATA_W-1:0] rdata_reg;
    logic              rvalid_reg;

`ifdef DP_MEM_BYPASS_EN
    logic same_addr;
    assign same_addr = user_we && (i_waddr == i_raddr);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
        end else begin
            rvalid_reg <= user_re;
            if (user_re) begin
                rdata_reg <= same_addr ? i_wdata : mem[i_raddr];
            end
        end
    end
`else
    // Read-first: the array read sees the word from before this edge's write.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
        end else begin
            rvalid_reg <= user_re;
            if (user_re) begin
                rdata_reg <= mem[i_raddr];
            end
        end
    end
`endif

    assign o_rdata  = rdata_reg;
    assign o_rvalid = rvalid_reg;
    assign o_busy   = busy;

endmodule : dp_mem_param

// File: doc/dp_mem_param.md
DP_MEM_PARAM -- requirements
Module: dp_mem_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data width in bits, at least 1.
REQ-002 SHALL have parameter ADDR_W, default 9: address width; depth is DEPTH = 2^ADDR_W words.
REQ-003 SHALL have parameter CLR_VAL, default 0: DATA_W-bit word written to every location during clear.
REQ-004 Port i_clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port i_rst, input, 1: reset, synchronous, active-high.
REQ-006 Port i_clr, input, 1: one-cycle request to re-run the clear sequence.
REQ-007 Port i_we, input, 1: write enable.
REQ-008 Port i_waddr, input, ADDR_W: write address.
REQ-009 Port i_wdata, input, DATA_W: write data.
REQ-010 Port i_re, input, 1: read enable.
REQ-011 Port i_raddr, input, ADDR_W: read address.
REQ-012 Port o_rdata, output, DATA_W: registered read data.
REQ-013 Port o_rvalid, output, 1: o_rdata updated this cycle.
REQ-014 Port o_busy, output, 1: clear sequence in progress; user accesses are ignored.

Function
REQ-015 SHALL implement a two-state FSM, CLEAR and READY; reset enters CLEAR.
REQ-016 In CLEAR, SHALL write CLR_VAL to the address held in an ADDR_W-bit clear counter, then increment it, one word per cycle from 0.
REQ-017 SHALL leave CLEAR for READY in the cycle after writing address DEPTH-1; the sweep takes exactly DEPTH cycles and the counter wraps to 0.
REQ-018 o_busy SHALL be 1 in every CLEAR cycle and 0 in READY.
REQ-019 In CLEAR, SHALL ignore i_we and i_re; o_rvalid stays 0 and o_rdata holds its value.
REQ-020 i_clr in READY SHALL enter CLEAR on the next cycle with the counter at 0; i_clr in CLEAR SHALL restart the counter at 0.
REQ-021 In READY, i_we=1 SHALL write i_wdata to i_waddr at the clock edge.
REQ-022 In READY, i_re=1 SHALL set o_rdata to mem[i_raddr] and o_rvalid to 1 on the next cycle (latency 1).
REQ-023 o_rvalid SHALL be 1 for exactly one cycle per accepted read; back-to-back reads give one result per cycle.
REQ-024 When i_re=0, o_rdata SHALL hold its previous value and o_rvalid SHALL be 0.
REQ-025 A read and a write to different addresses in the same cycle SHALL both complete independently.
REQ-026 A read and a write to the same address in the same cycle SHALL follow REQ-032.
REQ-027 Addresses SHALL be used modulo DEPTH; there are no out-of-range cases.

Reset
REQ-028 While i_rst=1: FSM SHALL be CLEAR, clear counter 0, o_rdata 0, o_rvalid 0, o_busy 1.
REQ-029 i_rst asserted mid-clear or mid-read SHALL abort the operation; the sweep restarts at address 0 once i_rst is released.
REQ-030 Array contents SHALL not be reset directly; only the clear sequence initialises them.

Configuration
REQ-031 Macro DP_MEM_BYPASS_EN SHALL select read-during-write behaviour.
REQ-032 With DP_MEM_BYPASS_EN defined, a same-address read/write SHALL return the new i_wdata on o_rdata (write-first); without it, the old stored word (read-first).

Structure
REQ-033 The FSM state encoding and the default width/depth constants SHALL live in shared package dp_mem_pkg.
REQ-034 The clear counter and FSM SHALL be a sub-module, dp_mem_clr_seq, outputting busy, clear address and clear write-enable.
REQ-035 The storage array SHALL be written from one port muxed between the clear sequencer and the user, so it still infers block RAM.

Verification
REQ-036 Release reset with DATA_W=8, ADDR_W=4 -> o_busy=1 for exactly 16 cycles; then reads of addresses 0..15 all return 0x00.
REQ-037 Write 0xA5 to addr 3, then read addr 3 the following cycle -> o_rdata=0xA5 with o_rvalid=1 exactly one cycle after i_re.
REQ-038 Same-cycle write 0x5A and read of addr 7, which holds 0x11 -> 0x5A with DP_MEM_BYPASS_EN, 0x11 without.
REQ-039 Pulse i_clr at clear-counter value 9 -> counter restarts at 0, o_busy lasts 16 more cycles, and a write of 0xFF issued during the sweep is absent afterwards.
REQ-040 Assert i_rst for one cycle during a read burst -> o_rvalid=0 and o_rdata=0 next cycle, then a full 16-cycle sweep runs.
